// File: rtl/int2fp_arb_if.sv
// Bundle of the request, converter, result and flag-control signals of int2fp_arb.
// slave = the arbiter, master = its environment (issue pipes, converter, consumer).
interface int2fp_arb_if #(
  parameter int TAGW = 5
);
  logic            req0_valid;
  logic            req0_ready;
  logic [63:0]     req0_rs1;
  logic [2:0]      req0_rm;
  logic            req0_fp64;
  logic [3:0]      req0_ctrl;
  logic [TAGW-1:0] req0_tag;

  logic            req1_valid;
  logic            req1_ready;
  logic [63:0]     req1_rs1;
  logic [2:0]      req1_rm;
  logic            req1_fp64;
  logic [3:0]      req1_ctrl;
  logic [TAGW-1:0] req1_tag;

  logic [63:0]     cvt_rs1;
  logic [2:0]      cvt_rm;
  logic            cvt_fp64;
  logic [3:0]      cvt_ctrl;
  logic [64:0]     cvt_data;
  logic [4:0]      cvt_exc;

  logic            res_valid;
  logic            res_ready;
  logic            res_pipe;
  logic [TAGW-1:0] res_tag;
  logic [64:0]     res_data;
  logic [4:0]      res_exc;
  logic            res_illegal;

  logic            flush;
  logic            fflags_clr;
  logic [4:0]      fflags_acc;

  modport slave (
    input  req0_valid, req0_rs1, req0_rm, req0_fp64, req0_ctrl, req0_tag,
    output req0_ready,
    input  req1_valid, req1_rs1, req1_rm, req1_fp64, req1_ctrl, req1_tag,
    output req1_ready,
    output cvt_rs1, cvt_rm, cvt_fp64, cvt_ctrl,
    input  cvt_data, cvt_exc,
    output res_valid, res_pipe, res_tag, res_data, res_exc, res_illegal,
    input  res_ready,
    input  flush, fflags_clr,
    output fflags_acc
  );

  modport master (
    output req0_valid, req0_rs1, req0_rm, req0_fp64, req0_ctrl, req0_tag,
    input  req0_ready,
    output req1_valid, req1_rs1, req1_rm, req1_fp64, req1_ctrl, req1_tag,
    input  req1_ready,
    input  cvt_rs1, cvt_rm, cvt_fp64, cvt_ctrl,
    output cvt_data, cvt_exc,
    input  res_valid, res_pipe, res_tag, res_data, res_exc, res_illegal,
    output res_ready,
    output flush, fflags_clr,
    input  fflags_acc
  );
endinterface

// File: rtl/int2fp_arb.sv
// Round-robin arbiter of two issue pipes onto one shared int-to-FP converter, 2-stage pipeline.
// Optional sticky exception-flag accumulator enabled by defining INT2FP_ARB_FFLAGS_ACCUM_EN.
module int2fp_arb #(
  parameter int TAGW = 5
) (
  input logic         clk,
  input logic         rst_l,
  int2fp_arb_if.slave bus
);

  typedef struct packed {
    logic [63:0] rs1;
    logic [2:0]  rm;
    logic        fp64;
    logic [3:0]  ctrl;  // {fcvt, fmv, sign, long}
  } op_t;

  // S1: operands presented to the converter
  logic            r_s1_valid;
  op_t             r_s1_op;
  logic [TAGW-1:0] r_s1_tag;
  logic            r_s1_pipe;

  // S2: captured converter result
  logic            r_s2_valid;
  logic [64:0]     r_s2_data;
  logic [4:0]      r_s2_exc;
  logic [TAGW-1:0] r_s2_tag;
  logic            r_s2_pipe;
  logic            r_s2_illegal;

  logic            r_ptr;  // pipe favoured when both request

  logic            w_advance;
  logic            w_accept_ok;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic            w_illegal;
  op_t             w_req_op;
  logic [TAGW-1:0] w_req_tag;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_advance   = !r_s2_valid | bus.res_ready;
    // Reset gating keeps both ready outputs low while rst_l is held.
    w_accept_ok = (!r_s1_valid | w_advance) & !bus.flush & rst_l;
    w_gnt0      = bus.req0_valid & (!bus.req1_valid | !r_ptr);
    w_gnt1      = bus.req1_valid & (!bus.req0_valid |  r_ptr);
    w_accept    = w_accept_ok & (w_gnt0 | w_gnt1);
    w_illegal   = r_s1_op.ctrl[3] ~^ r_s1_op.ctrl[2];
    w_req_op    = '{rs1: bus.req0_rs1, rm: bus.req0_rm, fp64: bus.req0_fp64, ctrl: bus.req0_ctrl};
    w_req_tag   = bus.req0_tag;
    if (w_gnt1) begin
      w_req_op  = '{rs1: bus.req1_rs1, rm: bus.req1_rm, fp64: bus.req1_fp64, ctrl: bus.req1_ctrl};
      w_req_tag = bus.req1_tag;
    end
  end

  assign bus.req0_ready = w_accept_ok & w_gnt0;
  assign bus.req1_ready = w_accept_ok & w_gnt1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
      r_s1_pipe  <= 1'b0;
      r_ptr      <= 1'b0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
      r_s1_pipe  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= w_req_op;
      r_s1_tag   <= w_req_tag;
      r_s1_pipe  <= w_gnt1;
      r_ptr      <= !w_gnt1;
    end else if (r_s1_valid && w_advance) begin
      // Emptied S1 returns the converter operands to zero.
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
      r_s1_pipe  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s2_valid   <= 1'b0;
      r_s2_data    <= '0;
      r_s2_exc     <= '0;
      r_s2_tag     <= '0;
      r_s2_pipe    <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_s2_valid <= 1'b0;
    end else if (r_s1_valid && w_advance) begin
      r_s2_valid   <= 1'b1;
      r_s2_data    <= w_illegal ? 65'd0 : bus.cvt_data;
      r_s2_exc     <= w_illegal ? 5'b10000 : bus.cvt_exc;
      r_s2_tag     <= r_s1_tag;
      r_s2_pipe    <= r_s1_pipe;
      r_s2_illegal <= w_illegal;
    end else if (bus.res_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.cvt_rs1     = r_s1_op.rs1;
  assign bus.cvt_rm      = r_s1_op.rm;
  assign bus.cvt_fp64    = r_s1_op.fp64;
  assign bus.cvt_ctrl    = r_s1_op.ctrl;

  assign bus.res_valid   = r_s2_valid;
  assign bus.res_pipe    = r_s2_pipe;
  assign bus.res_tag     = r_s2_tag;
  assign bus.res_data    = r_s2_data;
  assign bus.res_exc     = r_s2_exc;
  assign bus.res_illegal = r_s2_illegal;

`ifdef INT2FP_ARB_FFLAGS_ACCUM_EN
  logic [4:0] r_fflags;
  logic       w_res_hs;

  assign w_res_hs = r_s2_valid & bus.res_ready;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_fflags <= '0;
    end else if (bus.fflags_clr) begin
      r_fflags <= w_res_hs ? r_s2_exc : 5'd0;
    end else if (w_res_hs) begin
      r_fflags <= r_fflags | r_s2_exc;
    end
  end

  assign bus.fflags_acc = r_fflags;
`else
  logic w_unused_fflags_clr;
  assign w_unused_fflags_clr = bus.fflags_clr;
  assign bus.fflags_acc      = 5'd0;
`endif

endmodule
